// File: rtl/force_release_pkg.sv
// Shared types for the force/release controller: command opcodes, FSM states
// and the bit-range legality check.
package force_release_pkg;

  typedef enum logic [1:0] {
    OP_FORCE       = 2'd0,
    OP_RELEASE     = 2'd1,
    OP_READ        = 2'd2,
    OP_RELEASE_ALL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic range_ok(input int unsigned lsb, input int unsigned msb,
                                    input int unsigned width);
    return (msb >= lsb) && (msb < width);
  endfunction

endpackage

// File: rtl/force_mask_gen.sv
// Combinational bit-range mask: bits lsb..msb (inclusive) set, all others clear.
// An inverted range yields an all-zero mask.
module force_mask_gen #(
  parameter int WIDTH = 32,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [IW-1:0]    lsb,
  input  logic [IW-1:0]    msb,
  output logic [WIDTH-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i >= int'(lsb)) && (i <= int'(msb));
    end
  end

endmodule

// File: rtl/force_release_ctrl.sv
// Force/release controller: resolves forced, held and driven bits onto sig_rd
// and executes one latched command at a time through IDLE -> APPLY -> RESP.
module force_release_ctrl
  import force_release_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit RELEASE_HOLD = 1'b0,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             drv_upd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_lsb,
  input  logic [IW-1:0]    cmd_msb,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] sig_rd,
  output logic             any_forced
);

  state_e           state, state_nxt;
  logic             apply;
  op_e              op_q;
  logic [IW-1:0]    lsb_q, msb_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] force_en, force_val, hold_en, hold_val;
  logic [WIDTH-1:0] force_en_nxt, force_val_nxt, hold_en_nxt, hold_val_nxt;
  logic [WIDTH-1:0] range_mask, mask, rel_mask, rd_nxt;
  logic             cmd_err;

  // Per bit: a force beats a held value, which beats the live driver.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] en,
                                               input logic [WIDTH-1:0] val,
                                               input logic [WIDTH-1:0] hen,
                                               input logic [WIDTH-1:0] hval,
                                               input logic [WIDTH-1:0] s);
    return (en & val) | (~en & hen & hval) | (~en & ~hen & s);
  endfunction

  force_mask_gen #(.WIDTH(WIDTH)) u_mask (
    .lsb  (lsb_q),
    .msb  (msb_q),
    .mask (range_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    apply      = (state == ST_APPLY);
  end

  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      op_q   <= op_e'(cmd_op);
      lsb_q  <= cmd_lsb;
      msb_q  <= cmd_msb;
      data_q <= cmd_data;
    end
  end

  // A drv_upd clears holds first so a coincident release can re-establish them.
  always_comb begin
    mask          = (op_q == OP_RELEASE_ALL) ? '1 : range_mask;
    rel_mask      = mask & force_en;
    cmd_err       = ((op_q == OP_FORCE) || (op_q == OP_RELEASE)) &&
                    !range_ok(32'(lsb_q), 32'(msb_q), WIDTH);
    force_en_nxt  = force_en;
    force_val_nxt = force_val;
    hold_en_nxt   = drv_upd ? '0 : hold_en;
    hold_val_nxt  = hold_val;
    if (apply && !cmd_err) begin
      case (op_q)
        OP_FORCE: begin
          force_en_nxt  = force_en | mask;
          force_val_nxt = (force_val & ~mask) | ((data_q << lsb_q) & mask);
          hold_en_nxt   = hold_en_nxt & ~mask;
        end
        OP_RELEASE, OP_RELEASE_ALL: begin
          force_en_nxt = force_en & ~mask;
          if (RELEASE_HOLD) begin
            hold_en_nxt  = hold_en_nxt | rel_mask;
            hold_val_nxt = (hold_val & ~rel_mask) | (force_val & rel_mask);
          end
        end
        default: ;
      endcase
    end
    rd_nxt = resolve(force_en_nxt, force_val_nxt, hold_en_nxt, hold_val_nxt, sig_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_en  <= '0;
      force_val <= '0;
      hold_en   <= '0;
      hold_val  <= '0;
      resp_err  <= 1'b0;
      resp_data <= '0;
    end else begin
      force_en  <= force_en_nxt;
      force_val <= force_val_nxt;
      hold_en   <= hold_en_nxt;
      hold_val  <= hold_val_nxt;
      if (apply) begin
        resp_err  <= cmd_err;
        resp_data <= rd_nxt;
      end
    end
  end

  assign sig_rd     = resolve(force_en, force_val, hold_en, hold_val, sig_in);
  assign any_forced = |force_en;

endmodule

// File: tb/tb_force_release_ctrl.sv
// Bench for force_release_ctrl: a net-semantics and a variable-semantics instance
// share stimulus and are compared against a per-bit reference model.
module tb_force_release_ctrl;

  localparam int W = 32;
  localparam logic [1:0] F = 2'd0, R = 2'd1, RD = 2'd2, RA = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sig_in = '0;
  logic         drv_upd = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [4:0]   cmd_lsb = '0, cmd_msb = '0;
  logic [W-1:0] cmd_data = '0;
  logic         resp_ready = 1'b1;

  logic         cmd_ready[2], resp_valid[2], resp_err[2], any_forced[2];
  logic [W-1:0] resp_data[2], sig_rd[2];

  always #5 clk = ~clk;

  force_release_ctrl #(.WIDTH(W), .RELEASE_HOLD(1'b0)) u_net (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .drv_upd(drv_upd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
    .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_data(cmd_data),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_err(resp_err[0]),
    .resp_data(resp_data[0]), .sig_rd(sig_rd[0]), .any_forced(any_forced[0]));

  force_release_ctrl #(.WIDTH(W), .RELEASE_HOLD(1'b1)) u_var (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .drv_upd(drv_upd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
    .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_data(cmd_data),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_err(resp_err[1]),
    .resp_data(resp_data[1]), .sig_rd(sig_rd[1]), .any_forced(any_forced[1]));

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = net semantics, index 1 = variable semantics.
  bit mf[2][W], mv[2][W], mh[2][W], mhv[2][W];

  logic [W-1:0] cap_data[2];
  logic         cap_err[2];

  typedef struct {
    logic [1:0]   op;
    int           lsb;
    int           msb;
    logic [W-1:0] data;
    logic [W-1:0] sig;
    bit           upd;
    int           hold;
    logic [W-1:0] exp_net;
    logic [W-1:0] exp_var;
    bit           exp_err;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [W-1:0] m_rd(int k, logic [W-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = mf[k][i] ? mv[k][i] : (mh[k][i] ? mhv[k][i] : s[i]);
    return r;
  endfunction

  function automatic logic m_any(int k);
    logic a = 1'b0;
    for (int i = 0; i < W; i++) a = a | mf[k][i];
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < W; i++) begin
        mf[k][i] = 0; mv[k][i] = 0; mh[k][i] = 0; mhv[k][i] = 0;
      end
  endtask

  task automatic model_upd();
    for (int i = 0; i < W; i++) mh[1][i] = 0;
  endtask

  task automatic model_apply(input logic [1:0] op, input int lsb, input int msb,
                             input logic [W-1:0] data, output bit err);
    int lo, hi;
    err = ((op == F) || (op == R)) && (msb < lsb);
    if (err || op == RD) return;
    lo = (op == RA) ? 0 : lsb;
    hi = (op == RA) ? W - 1 : msb;
    for (int k = 0; k < 2; k++)
      for (int i = lo; i <= hi; i++) begin
        if (op == F) begin
          mf[k][i] = 1; mv[k][i] = data[i - lo]; mh[k][i] = 0;
        end else if (mf[k][i]) begin
          if (k == 1) begin mh[k][i] = 1; mhv[k][i] = mv[k][i]; end
          mf[k][i] = 0;
        end
      end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s sig_rd[%0d]", tag, k), sig_rd[k], m_rd(k, sig_in));
      chk($sformatf("%s any_forced[%0d]", tag, k), 32'(any_forced[k]), 32'(m_any(k)));
    end
  endtask

  task automatic cyc(input bit upd);
    drv_upd = upd;
    @(posedge clk);
    if (upd) model_upd();
    #1;
    drv_upd = 1'b0;
    chk_rd("cycle");
  endtask

  // Full command: accept, APPLY (optional drv_upd), RESP held for 'hold' extra cycles.
  task automatic do_cmd(input logic [1:0] op, input int lsb, input int msb,
                        input logic [W-1:0] data, input bit upd, input int hold);
    bit           merr;
    logic [W-1:0] exp_d[2];
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("idle cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd1);
      chk($sformatf("idle resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_lsb = lsb[4:0]; cmd_msb = msb[4:0]; cmd_data = data;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_lsb = 5'($urandom); cmd_data = $urandom;
    drv_upd = upd;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("apply cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd0);
      chk($sformatf("apply resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
    end
    @(posedge clk);
    if (upd) model_upd();
    model_apply(op, lsb, msb, data, merr);
    #1;
    drv_upd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_d[k] = m_rd(k, sig_in);
      cap_data[k] = resp_data[k];
      cap_err[k] = resp_err[k];
      chk($sformatf("resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd1);
      chk($sformatf("resp_err[%0d]", k), 32'(resp_err[k]), 32'(merr));
      chk($sformatf("resp_data[%0d]", k), resp_data[k], exp_d[k]);
    end
    chk_rd("post-apply");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd1);
        chk($sformatf("stall resp_data[%0d]", k), resp_data[k], exp_d[k]);
        chk($sformatf("stall resp_err[%0d]", k), 32'(resp_err[k]), 32'(merr));
        chk($sformatf("stall cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("done cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd1);
    end
  endtask

  initial begin
    tbl[0]  = '{F,  0, 31, 32'h55555555, 32'hAAAAAAAA, 0, 0, 32'h55555555, 32'h55555555, 0};
    tbl[1]  = '{RD, 0,  0, 32'h0,        32'h00000000, 0, 0, 32'h55555555, 32'h55555555, 0};
    tbl[2]  = '{RA, 0,  0, 32'h0,        32'hAAAAAAAA, 0, 0, 32'hAAAAAAAA, 32'h55555555, 0};
    tbl[3]  = '{F,  0, 15, 32'h00005555, 32'hAAAAAAAA, 1, 0, 32'hAAAA5555, 32'hAAAA5555, 0};
    tbl[4]  = '{R,  0, 15, 32'h0,        32'hAAAAAAAA, 0, 0, 32'hAAAAAAAA, 32'hAAAA5555, 0};
    tbl[5]  = '{F,  8,  4, 32'h0000FFFF, 32'hAAAAAAAA, 0, 5, 32'hAAAAAAAA, 32'hAAAA5555, 1};
    tbl[6]  = '{R, 16, 31, 32'h0,        32'hAAAAAAAA, 0, 0, 32'hAAAAAAAA, 32'hAAAA5555, 0};
    tbl[7]  = '{R,  0, 15, 32'h0,        32'hAAAAAAAA, 1, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 0};
    tbl[8]  = '{F,  4, 11, 32'h000000F0, 32'hAAAAAAAA, 0, 0, 32'hAAAAAF0A, 32'hAAAAAF0A, 0};
    tbl[9]  = '{F,  4, 11, 32'h0000000F, 32'hAAAAAAAA, 0, 0, 32'hAAAAA0FA, 32'hAAAAA0FA, 0};
    tbl[10] = '{R,  0, 31, 32'h0,        32'hAAAAAAAA, 1, 0, 32'hAAAAAAAA, 32'hAAAAA0FA, 0};
    tbl[11] = '{RD, 0,  0, 32'h0,        32'h00000000, 0, 0, 32'h00000000, 32'h000000F0, 0};
    tbl[12] = '{F, 31, 31, 32'h00000001, 32'h00000000, 0, 0, 32'h80000000, 32'h800000F0, 0};
    tbl[13] = '{RA, 8,  4, 32'h0,        32'h00000000, 0, 0, 32'h00000000, 32'h800000F0, 0};

    model_reset();
    sig_in = 32'hAAAAAAAA;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst sig_rd[%0d]", k), sig_rd[k], 32'hAAAAAAAA);
      chk($sformatf("rst any_forced[%0d]", k), 32'(any_forced[k]), 32'd0);
      chk($sformatf("rst cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd1);
      chk($sformatf("rst resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("rst resp_err[%0d]", k), 32'(resp_err[k]), 32'd0);
      chk($sformatf("rst resp_data[%0d]", k), resp_data[k], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_rd("after reset");

    for (int t = 0; t < 14; t++) begin
      sig_in = tbl[t].sig;
      do_cmd(tbl[t].op, tbl[t].lsb, tbl[t].msb, tbl[t].data, tbl[t].upd, tbl[t].hold);
      chk($sformatf("row%0d resp_data net", t), cap_data[0], tbl[t].exp_net);
      chk($sformatf("row%0d resp_data var", t), cap_data[1], tbl[t].exp_var);
      chk($sformatf("row%0d resp_err", t), 32'(cap_err[0]), 32'(tbl[t].exp_err));
      chk($sformatf("row%0d sig_rd net", t), sig_rd[0], tbl[t].exp_net);
      chk($sformatf("row%0d sig_rd var", t), sig_rd[1], tbl[t].exp_var);
    end

    // Held bits yield to the driver after one drv_upd pulse.
    sig_in = 32'hAAAAAAAA;
    #1;
    chk("pre-upd sig_rd var", sig_rd[1], 32'hAAAAA0FA);
    cyc(1'b1);
    chk("post-upd sig_rd var", sig_rd[1], 32'hAAAAAAAA);
    chk("post-upd sig_rd net", sig_rd[0], 32'hAAAAAAAA);

    // Reset during APPLY drops the command and every force.
    do_cmd(F, 0, 31, 32'h12345678, 1'b0, 0);
    cmd_valid = 1'b1; cmd_op = F; cmd_lsb = 5'd0; cmd_msb = 5'd7; cmd_data = 32'hFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst sig_rd[%0d]", k), sig_rd[k], 32'hAAAAAAAA);
      chk($sformatf("midrst any_forced[%0d]", k), 32'(any_forced[k]), 32'd0);
      chk($sformatf("midrst resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("midrst cmd_ready[%0d]", k), 32'(cmd_ready[k]), 32'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("postrst resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
      chk_rd("postrst");
    end

    // Randomised traffic with driver activity between commands.
    for (int n = 0; n < 200; n++) begin
      int gaps, lsb, msb;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        sig_in = $urandom;
        #1;
        chk_rd("zero-latency");
        cyc(bit'($urandom_range(0, 1)));
      end
      lsb = $urandom_range(0, 31);
      msb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(lsb, 31);
      do_cmd(2'($urandom), lsb, msb, $urandom, bit'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
